main_control_fsm: RTL and testbench



---
 rtl/mips_ctrl_pkg.sv | 97 +++++++++
 rtl/main_control_fsm_if.sv | 46 ++++
 rtl/alu_decoder.sv | 41 ++++
 rtl/main_control_fsm.sv | 181 ++++++++++++++++++
 tb/tb_main_control_fsm.sv | 204 ++++++++++++++++++++
 5 files changed

// File: rtl/mips_ctrl_pkg.sv
// Shared constants, state encoding and control bundle
// for the multi-cycle MIPS main control unit.
package mips_ctrl_pkg;

  localparam int OPCODE_WIDTH = 6;
  localparam int FUNCT_WIDTH  = 6;

  localparam logic [5:0] OP_R    = 6'h00;
  localparam logic [5:0] OP_J    = 6'h02;
  localparam logic [5:0] OP_JAL  = 6'h03;
  localparam logic [5:0] OP_BEQ  = 6'h04;
  localparam logic [5:0] OP_BNE  = 6'h05;
  localparam logic [5:0] OP_ADDI = 6'h08;
  localparam logic [5:0] OP_SLTI = 6'h0A;
  localparam logic [5:0] OP_ANDI = 6'h0C;
  localparam logic [5:0] OP_ORI  = 6'h0D;
  localparam logic [5:0] OP_LB   = 6'h20;
  localparam logic [5:0] OP_LH   = 6'h21;
  localparam logic [5:0] OP_LW   = 6'h23;
  localparam logic [5:0] OP_LBU  = 6'h24;
  localparam logic [5:0] OP_LHU  = 6'h25;
  localparam logic [5:0] OP_SW   = 6'h2B;

  localparam logic [5:0] F_SLL  = 6'h00;
  localparam logic [5:0] F_JR   = 6'h08;
  localparam logic [5:0] F_ADD  = 6'h20;
  localparam logic [5:0] F_ADDU = 6'h21;
  localparam logic [5:0] F_SUB  = 6'h22;
  localparam logic [5:0] F_SUBU = 6'h23;
  localparam logic [5:0] F_AND  = 6'h24;
  localparam logic [5:0] F_OR   = 6'h25;
  localparam logic [5:0] F_SLT  = 6'h2A;

  localparam logic [3:0] ALU_ADD    = 4'd0;
  localparam logic [3:0] ALU_SUB    = 4'd1;
  localparam logic [3:0] ALU_AND    = 4'd2;
  localparam logic [3:0] ALU_OR     = 4'd3;
  localparam logic [3:0] ALU_SLT    = 4'd4;
  localparam logic [3:0] ALU_SLL    = 4'd5;
  localparam logic [3:0] ALU_CMP_EQ = 4'd6;
  localparam logic [3:0] ALU_CMP_NE = 4'd7;

  localparam logic [1:0] PC_ALU    = 2'd0;
  localparam logic [1:0] PC_ALUREG = 2'd1;
  localparam logic [1:0] PC_JUMP   = 2'd2;
  localparam logic [1:0] PC_EXC    = 2'd3;

  localparam logic [2:0] SEL2_B    = 3'd0;
  localparam logic [2:0] SEL2_FOUR = 3'd1;
  localparam logic [2:0] SEL2_IMM  = 3'd2;
  localparam logic [2:0] SEL2_BR   = 3'd3;
  localparam logic [2:0] SEL2_ZERO = 3'd4;

  localparam logic [1:0] DEST_RT = 2'd0;
  localparam logic [1:0] DEST_RD = 2'd1;
  localparam logic [1:0] DEST_RA = 2'd2;

  localparam logic [2:0] M2R_ALU = 3'd0;
  localparam logic [2:0] M2R_MEM = 3'd4;
  localparam logic [2:0] M2R_PC  = 3'd5;

  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_ALU_EXEC,
    S_JR,
    S_MEM_ADDR,
    S_MEM_READ,
    S_MEM_WB,
    S_MEM_WRITE,
    S_BRANCH,
    S_JUMP,
    S_JAL,
    S_EXCEPTION
  } state_e;

  typedef struct packed {
    logic       pc_en;
    logic       ir_en;
    logic       mem_rd;
    logic       mem_wr;
    logic       iord;
    logic       epc_en;
    logic [1:0] pc_src;
    logic [2:0] reg_data_sel;
    logic [2:0] mem_to_reg;
    logic [2:0] alu_sel2;
    logic [1:0] reg_dest;
    logic       reg_ws;
    logic       cause_en;
    logic       cause_sel;
    logic       alu_sel1;
    logic       signext_sel;
    logic [3:0] alu_control;
  } ctrl_t;

endpackage

// File: rtl/main_control_fsm_if.sv
// Control/status bundle between the main control FSM
// and the datapath.
interface main_control_fsm_if;
  import mips_ctrl_pkg::*;

  logic [OPCODE_WIDTH-1:0] OPCODE;
  logic [FUNCT_WIDTH-1:0]  FUNCT;
  logic       OF_OUT;
  logic       BF_OUT;
  logic       PC_EN;
  logic       IR_EN;
  logic       MEM_RD;
  logic       MEM_WR;
  logic       IorD;
  logic       EPC_EN;
  logic [1:0] PC_SRC;
  logic [2:0] REG_DATA_SEL;
  logic [2:0] MEMtoREG;
  logic [2:0] ALU_SEL2;
  logic [1:0] Reg_Dest;
  logic       REG_WS;
  logic       CAUSE_EN;
  logic       CAUSE_SEL;
  logic       ALU_SEL1;
  logic       SIGNEXT_SEL;
  logic [3:0] ALU_CONTROL;

  modport master (
    input  OPCODE, FUNCT, OF_OUT, BF_OUT,
    output PC_EN, IR_EN, MEM_RD, MEM_WR, IorD,
    output EPC_EN, PC_SRC, REG_DATA_SEL, MEMtoREG,
    output ALU_SEL2, Reg_Dest, REG_WS, CAUSE_EN,
    output CAUSE_SEL, ALU_SEL1, SIGNEXT_SEL,
    output ALU_CONTROL
  );

  modport slave (
    output OPCODE, FUNCT, OF_OUT, BF_OUT,
    input  PC_EN, IR_EN, MEM_RD, MEM_WR, IorD,
    input  EPC_EN, PC_SRC, REG_DATA_SEL, MEMtoREG,
    input  ALU_SEL2, Reg_Dest, REG_WS, CAUSE_EN,
    input  CAUSE_SEL, ALU_SEL1, SIGNEXT_SEL,
    input  ALU_CONTROL
  );

endinterface

// File: rtl/alu_decoder.sv
// Maps opcode/funct to an ALU operation and flags the
// ops whose signed overflow must trap.
module alu_decoder
  import mips_ctrl_pkg::*;
(
  input  logic [OPCODE_WIDTH-1:0] opcode,
  input  logic [FUNCT_WIDTH-1:0]  funct,
  output logic [3:0]              alu_control,
  output logic                    trap_ovf
);

  always_comb begin
    alu_control = ALU_ADD;
    trap_ovf    = 1'b0;
    unique case (opcode)
      OP_R: begin
        unique case (funct)
          F_SLL:  alu_control = ALU_SLL;
          F_ADD:  trap_ovf    = 1'b1;
          F_SUB: begin
            alu_control = ALU_SUB;
            trap_ovf    = 1'b1;
          end
          F_SUBU: alu_control = ALU_SUB;
          F_AND:  alu_control = ALU_AND;
          F_OR:   alu_control = ALU_OR;
          F_SLT:  alu_control = ALU_SLT;
          default: alu_control = ALU_ADD;
        endcase
      end
      OP_ADDI: trap_ovf    = 1'b1;
      OP_SLTI: alu_control = ALU_SLT;
      OP_ANDI: alu_control = ALU_AND;
      OP_ORI:  alu_control = ALU_OR;
      OP_BEQ:  alu_control = ALU_CMP_EQ;
      OP_BNE:  alu_control = ALU_CMP_NE;
      default: alu_control = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/main_control_fsm.sv
// Multi-cycle MIPS main control: one instruction in
// flight, 3-5 cycles per instruction class.
module main_control_fsm
  import mips_ctrl_pkg::*;
#(
  parameter bit TRAP_OVERFLOW = 1'b1
) (
  input logic CLK,
  input logic RST,
  main_control_fsm_if.master bus
);

  state_e     state_q, state_d;
  logic       cause_q, cause_d;
  logic [3:0] dec_alu;
  logic       dec_trap;
  logic       r_ok;
  logic       ovf_trap;
  ctrl_t      ctl, ctl_o;

  alu_decoder u_alu_dec (
    .opcode      (bus.OPCODE),
    .funct       (bus.FUNCT),
    .alu_control (dec_alu),
    .trap_ovf    (dec_trap)
  );

  always_comb begin
    unique case (bus.FUNCT)
      F_SLL, F_ADD, F_ADDU, F_SUB,
      F_SUBU, F_AND, F_OR, F_SLT: r_ok = 1'b1;
      default: r_ok = 1'b0;
    endcase
  end

  assign ovf_trap = dec_trap & bus.OF_OUT
                  & TRAP_OVERFLOW;

  always_comb begin
    state_d = S_FETCH;
    cause_d = cause_q;
    ctl     = '0;
    unique case (state_q)
      S_FETCH: begin
        ctl.mem_rd   = 1'b1;
        ctl.ir_en    = 1'b1;
        ctl.alu_sel2 = SEL2_FOUR;
        ctl.pc_en    = 1'b1;
        state_d      = S_DECODE;
      end
      S_DECODE: begin
        ctl.alu_sel2 = SEL2_BR;
        state_d      = S_EXCEPTION;
        unique case (bus.OPCODE)
          OP_R: begin
            if (bus.FUNCT == F_JR) state_d = S_JR;
            else if (r_ok) state_d = S_ALU_EXEC;
            else cause_d = 1'b0;
          end
          OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI:
            state_d = S_ALU_EXEC;
          OP_LB, OP_LH, OP_LW,
          OP_LBU, OP_LHU, OP_SW:
            state_d = S_MEM_ADDR;
          OP_BEQ, OP_BNE: state_d = S_BRANCH;
          OP_J:   state_d = S_JUMP;
          OP_JAL: state_d = S_JAL;
          default: cause_d = 1'b0;
        endcase
      end
      S_ALU_EXEC: begin
        ctl.alu_sel1    = 1'b1;
        ctl.alu_control = dec_alu;
        if (bus.OPCODE == OP_R) begin
          ctl.alu_sel2 = SEL2_B;
          ctl.reg_dest = DEST_RD;
        end else begin
          ctl.alu_sel2    = SEL2_IMM;
          ctl.reg_dest    = DEST_RT;
          ctl.signext_sel = (bus.OPCODE == OP_ANDI)
                          | (bus.OPCODE == OP_ORI);
        end
        ctl.reg_ws = ~ovf_trap;
        if (ovf_trap) begin
          cause_d = 1'b1;
          state_d = S_EXCEPTION;
        end
      end
      S_JR: begin
        ctl.alu_sel1 = 1'b1;
        ctl.alu_sel2 = SEL2_ZERO;
        ctl.pc_en    = 1'b1;
      end
      S_MEM_ADDR: begin
        ctl.alu_sel1 = 1'b1;
        ctl.alu_sel2 = SEL2_IMM;
        state_d = (bus.OPCODE == OP_SW)
                ? S_MEM_WRITE : S_MEM_READ;
      end
      S_MEM_READ: begin
        ctl.mem_rd = 1'b1;
        ctl.iord   = 1'b1;
        state_d    = S_MEM_WB;
      end
      S_MEM_WB: begin
        ctl.reg_ws     = 1'b1;
        ctl.mem_to_reg = M2R_MEM;
        unique case (bus.OPCODE)
          OP_LBU:  ctl.reg_data_sel = 3'd1;
          OP_LB:   ctl.reg_data_sel = 3'd2;
          OP_LHU:  ctl.reg_data_sel = 3'd3;
          OP_LH:   ctl.reg_data_sel = 3'd4;
          default: ctl.reg_data_sel = 3'd0;
        endcase
      end
      S_MEM_WRITE: begin
        ctl.mem_wr = 1'b1;
        ctl.iord   = 1'b1;
      end
      S_BRANCH: begin
        ctl.alu_sel1    = 1'b1;
        ctl.alu_control = dec_alu;
        ctl.pc_src      = PC_ALUREG;
        ctl.pc_en       = bus.BF_OUT;
      end
      S_JUMP: begin
        ctl.pc_src = PC_JUMP;
        ctl.pc_en  = 1'b1;
      end
      S_JAL: begin
        ctl.pc_src     = PC_JUMP;
        ctl.pc_en      = 1'b1;
        ctl.reg_ws     = 1'b1;
        ctl.reg_dest   = DEST_RA;
        ctl.mem_to_reg = M2R_PC;
      end
      S_EXCEPTION: begin
        ctl.cause_en    = 1'b1;
        ctl.cause_sel   = cause_q;
        ctl.alu_sel2    = SEL2_FOUR;
        ctl.alu_control = ALU_SUB;
        ctl.epc_en      = 1'b1;
        ctl.pc_src      = PC_EXC;
        ctl.pc_en       = 1'b1;
      end
      default: state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= S_FETCH;
      cause_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cause_q <= cause_d;
    end
  end

  // Reset quiets every enable and select at once.
  assign ctl_o = RST ? '0 : ctl;

  assign bus.PC_EN        = ctl_o.pc_en;
  assign bus.IR_EN        = ctl_o.ir_en;
  assign bus.MEM_RD       = ctl_o.mem_rd;
  assign bus.MEM_WR       = ctl_o.mem_wr;
  assign bus.IorD         = ctl_o.iord;
  assign bus.EPC_EN       = ctl_o.epc_en;
  assign bus.PC_SRC       = ctl_o.pc_src;
  assign bus.REG_DATA_SEL = ctl_o.reg_data_sel;
  assign bus.MEMtoREG     = ctl_o.mem_to_reg;
  assign bus.ALU_SEL2     = ctl_o.alu_sel2;
  assign bus.Reg_Dest     = ctl_o.reg_dest;
  assign bus.REG_WS       = ctl_o.reg_ws;
  assign bus.CAUSE_EN     = ctl_o.cause_en;
  assign bus.CAUSE_SEL    = ctl_o.cause_sel;
  assign bus.ALU_SEL1     = ctl_o.alu_sel1;
  assign bus.SIGNEXT_SEL  = ctl_o.signext_sel;
  assign bus.ALU_CONTROL  = ctl_o.alu_control;

endmodule

// File: tb/tb_main_control_fsm.sv
// Directed bench for the main control FSM.
module tb_main_control_fsm;

  logic CLK;
  logic RST;
  int   total;
  int   bad;

  main_control_fsm_if bus ();

  main_control_fsm dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [7:0] obs,
                     input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] ens();
    return {1'b0, bus.PC_EN, bus.IR_EN, bus.MEM_RD,
            bus.MEM_WR, bus.REG_WS, bus.CAUSE_EN,
            bus.EPC_EN};
  endfunction

  task automatic instr(input logic [5:0] op,
                       input logic [5:0] fn);
    bus.OPCODE = op;
    bus.FUNCT  = fn;
    tick();
  endtask

  initial begin
    total = 0;
    bad   = 0;
    RST   = 1'b1;
    bus.OPCODE = 6'h00;
    bus.FUNCT  = 6'h00;
    bus.OF_OUT = 1'b0;
    bus.BF_OUT = 1'b0;
    #3;
    chk("rst_ens", ens(), 8'h00);
    chk("rst_sel2", 8'(bus.ALU_SEL2), 8'd0);
    tick();
    tick();
    RST = 1'b0;
    #1;
    chk("fetch_ens", ens(), 8'h70);
    chk("fetch_sel2", 8'(bus.ALU_SEL2), 8'd1);

    // lw interrupted by an off-edge reset pulse
    instr(6'h23, 6'h00);
    chk("dec_sel2", 8'(bus.ALU_SEL2), 8'd3);
    chk("dec_ir", 8'(bus.IR_EN), 8'd0);
    tick();
    chk("maddr_sel", {6'd0, bus.ALU_SEL1,
        bus.ALU_SEL2 == 3'd2}, 8'd3);
    tick();
    chk("mrd_rd", {6'd0, bus.MEM_RD, bus.IorD}, 8'd3);
    #2 RST = 1'b1;
    #1;
    chk("mrd_rst_ens", ens(), 8'h00);
    chk("mrd_rst_iord", 8'(bus.IorD), 8'd0);
    #1 RST = 1'b0;
    #1;
    chk("post_rst_ens", ens(), 8'h70);
    chk("post_rst_sel2", 8'(bus.ALU_SEL2), 8'd1);

    // add, no overflow
    instr(6'h00, 6'h20);
    tick();
    chk("add_ws", 8'(bus.REG_WS), 8'd1);
    chk("add_dest", 8'(bus.Reg_Dest), 8'd1);
    chk("add_alu", 8'(bus.ALU_CONTROL), 8'd0);
    chk("add_sel2", 8'(bus.ALU_SEL2), 8'd0);
    tick();
    chk("add_fetch", ens(), 8'h70);

    // add with overflow traps
    instr(6'h00, 6'h20);
    tick();
    bus.OF_OUT = 1'b1;
    #1;
    chk("addof_ws", 8'(bus.REG_WS), 8'd0);
    tick();
    bus.OF_OUT = 1'b0;
    chk("exc_ens", ens(), 8'h43);
    chk("exc_csel", 8'(bus.CAUSE_SEL), 8'd1);
    chk("exc_pcsrc", 8'(bus.PC_SRC), 8'd3);
    chk("exc_alu", 8'(bus.ALU_CONTROL), 8'd1);
    tick();
    chk("exc_fetch", ens(), 8'h70);

    // addu ignores overflow
    instr(6'h00, 6'h21);
    tick();
    bus.OF_OUT = 1'b1;
    #1;
    chk("addu_ws", 8'(bus.REG_WS), 8'd1);
    tick();
    bus.OF_OUT = 1'b0;
    chk("addu_fetch", ens(), 8'h70);

    // andi
    instr(6'h0C, 6'h00);
    tick();
    chk("andi_sx", 8'(bus.SIGNEXT_SEL), 8'd1);
    chk("andi_sel2", 8'(bus.ALU_SEL2), 8'd2);
    chk("andi_dest", 8'(bus.Reg_Dest), 8'd0);
    chk("andi_alu", 8'(bus.ALU_CONTROL), 8'd2);
    tick();

    // lb
    instr(6'h20, 6'h00);
    tick();
    tick();
    chk("lb_rd", {6'd0, bus.MEM_RD, bus.IorD}, 8'd3);
    tick();
    chk("lb_ws", 8'(bus.REG_WS), 8'd1);
    chk("lb_m2r", 8'(bus.MEMtoREG), 8'd4);
    chk("lb_rds", 8'(bus.REG_DATA_SEL), 8'd2);
    tick();
    chk("lb_fetch", ens(), 8'h70);

    // sw
    instr(6'h2B, 6'h00);
    tick();
    tick();
    chk("sw_ens", ens(), 8'h08);
    chk("sw_iord", 8'(bus.IorD), 8'd1);
    tick();
    chk("sw_fetch", ens(), 8'h70);

    // beq, both branch outcomes
    instr(6'h04, 6'h00);
    tick();
    chk("beq0_pcen", 8'(bus.PC_EN), 8'd0);
    chk("beq_pcsrc", 8'(bus.PC_SRC), 8'd1);
    chk("beq_alu", 8'(bus.ALU_CONTROL), 8'd6);
    bus.BF_OUT = 1'b1;
    #1;
    chk("beq1_pcen", 8'(bus.PC_EN), 8'd1);
    tick();
    bus.BF_OUT = 1'b0;

    // bne
    instr(6'h05, 6'h00);
    tick();
    chk("bne_alu", 8'(bus.ALU_CONTROL), 8'd7);
    tick();

    // jal
    instr(6'h03, 6'h00);
    tick();
    chk("jal_ens", ens(), 8'h44);
    chk("jal_pcsrc", 8'(bus.PC_SRC), 8'd2);
    chk("jal_dest", 8'(bus.Reg_Dest), 8'd2);
    chk("jal_m2r", 8'(bus.MEMtoREG), 8'd5);
    tick();

    // j
    instr(6'h02, 6'h00);
    tick();
    chk("j_ens", ens(), 8'h40);
    chk("j_pcsrc", 8'(bus.PC_SRC), 8'd2);
    tick();

    // jr
    instr(6'h00, 6'h08);
    tick();
    chk("jr_sel2", 8'(bus.ALU_SEL2), 8'd4);
    chk("jr_ens", ens(), 8'h40);
    tick();

    // undefined opcode
    instr(6'h3F, 6'h00);
    tick();
    chk("undef_ens", ens(), 8'h43);
    chk("undef_csel", 8'(bus.CAUSE_SEL), 8'd0);
    tick();
    chk("undef_fetch", ens(), 8'h70);

    $display("test done: total=%0d bad=%0d",
             total, bad);
    $finish;
  end

endmodule
